// File: rtl/prio_event_encoder.sv
// Registered priority event encoder: sticky pending capture, fixed or
// round-robin selection, and a valid/ready offer of the winning index.
module prio_event_encoder #(
    parameter int N       = 8,
    parameter int RR_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_idx,
    output logic [N-1:0]         pending,
    output logic                 overflow
);

    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           acc;
    logic [N-1:0]   clr;
    logic [N-1:0]   elig;
    logic           any;
    logic [N-1:0]   pending_nxt;
    logic           overflow_nxt;
    logic [W-1:0]   last_ptr;
    logic [W-1:0]   last_nxt;
    logic           valid_nxt;
    logic [W-1:0]   idx_nxt;
    logic [W:0]     start;
    logic [N-1:0]   rot;
    logic [W-1:0]   off;
    logic [W+1:0]   sum;
    logic [W-1:0]   sel;

    function automatic logic [W-1:0] lowest(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

    assign acc          = out_valid && out_ready;
    assign clr          = acc ? (N'(1) << out_idx) : '0;
    assign pending_nxt  = (pending & ~clr) | req;
    assign overflow_nxt = |(req & pending & ~clr);
    assign elig         = pending & ~clr & ~mask;
    assign any          = |elig;

    // Winner search; round-robin rotates the eligible set so the scan
    // starts just after the most recently accepted index.
    always_comb begin
        start = {1'b0, (acc ? out_idx : last_ptr)} + (W+1)'(1);
        rot   = N'({elig, elig} >> start);
        off   = lowest((RR_MODE != 0) ? rot : elig);
        sum   = (W+2)'(start) + (W+2)'(off);
        if (sum >= (W+2)'(N)) sum = sum - (W+2)'(N);
        sel   = (RR_MODE != 0) ? sum[W-1:0] : off;
    end

    // Offer FSM: next state, offer register and round-robin pointer.
    always_comb begin
        state_nxt = state;
        valid_nxt = out_valid;
        idx_nxt   = out_idx;
        last_nxt  = last_ptr;
        unique case (state)
            IDLE: begin
                if (en && any) begin
                    state_nxt = OFFER;
                    valid_nxt = 1'b1;
                    idx_nxt   = sel;
                end
            end
            OFFER: begin
                if (acc) begin
                    last_nxt = out_idx;
                    if (en && any) begin
                        idx_nxt = sel;
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // State, offer, pending and overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_idx   <= '0;
            last_ptr  <= W'(N - 1);
            pending   <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= valid_nxt;
            out_idx   <= idx_nxt;
            last_ptr  <= last_nxt;
            pending   <= pending_nxt;
            overflow  <= overflow_nxt;
        end
    end

endmodule
